// File: rtl/vga_timing_core.sv
// 640x480@60 scan timing and RGB332 -> 4:4:4 colour output stage.
// Optional colour-bar generator with input test_mode: define VGA_TEST_PATTERN_EN.
module vga_timing_core #(
  parameter int CLK_DIV      = 2,
  parameter int H_VISIBLE    = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int H_TOTAL      = 800,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int V_TOTAL      = 525
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in_red,
  input  logic [2:0] in_green,
  input  logic [1:0] in_blue,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       pix_en,
  output logic       blank,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [9:0] HVIS = 10'(H_VISIBLE);
  localparam logic [9:0] HSS  = 10'(H_SYNC_START);
  localparam logic [9:0] HSE  = 10'(H_SYNC_END);
  localparam logic [9:0] HLST = 10'(H_TOTAL - 1);
  localparam logic [9:0] VVIS = 10'(V_VISIBLE);
  localparam logic [9:0] VSS  = 10'(V_SYNC_START);
  localparam logic [9:0] VSE  = 10'(V_SYNC_END);
  localparam logic [9:0] VLST = 10'(V_TOTAL - 1);

  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_nxt;
  logic          r_pix_en;
  logic [9:0]    r_hc;
  logic [9:0]    r_vc;
  logic          r_blank;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_fs;
  logic [3:0]    r_red;
  logic [3:0]    r_green;
  logic [3:0]    r_blue;

  logic          w_h_last;
  logic          w_v_last;
  logic          w_vis;
  logic          w_hs_on;
  logic          w_vs_on;
  logic [2:0]    w_r;
  logic [2:0]    w_g;
  logic [1:0]    w_b;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]    w_bar;
`endif

  always_comb begin
    w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    w_h_last  = (r_hc >= HLST);
    w_v_last  = (r_vc >= VLST);
    w_vis     = (r_hc < HVIS) && (r_vc < VVIS);
    w_hs_on   = (r_hc >= HSS) && (r_hc < HSE);
    w_vs_on   = (r_vc >= VSS) && (r_vc < VSE);
    w_r       = in_red;
    w_g       = in_green;
    w_b       = in_blue;
`ifdef VGA_TEST_PATTERN_EN
    // Eight 64-pixel bars, bar index bits map to R/G/B
    w_bar     = r_hc[8:6];
    if (test_mode) begin
      w_r = {3{w_bar[2]}};
      w_g = {3{w_bar[1]}};
      w_b = {2{w_bar[0]}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= '0;
      r_pix_en <= 1'b0;
      r_hc     <= '0;
      r_vc     <= '0;
      r_blank  <= 1'b1;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
      r_fs     <= 1'b0;
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
    end else begin
      r_div    <= w_div_nxt;
      r_pix_en <= (w_div_nxt == DIV_LAST);
      r_fs     <= 1'b0;
      if (r_pix_en) begin
        r_hc <= w_h_last ? '0 : r_hc + 10'd1;
        if (w_h_last)
          r_vc <= w_v_last ? '0 : r_vc + 10'd1;
        // Outputs describe the pre-increment pixel
        r_hsync <= ~w_hs_on;
        r_vsync <= ~w_vs_on;
        r_blank <= ~w_vis;
        r_red   <= w_vis ? {w_r, w_r[2]} : 4'd0;
        r_green <= w_vis ? {w_g, w_g[2]} : 4'd0;
        r_blue  <= w_vis ? {w_b, w_b}    : 4'd0;
        r_fs    <= w_h_last && w_v_last;
      end
    end
  end

  assign hc          = r_hc;
  assign vc          = r_vc;
  assign pix_en      = r_pix_en;
  assign blank       = r_blank;
  assign frame_start = r_fs;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;

endmodule
